audio_adc_rx: RTL and testbench

//  Upstream audio front end for the voice game. Captures the WM8731 ADC I2S stream
//  (ADCDAT/ADCLRCK/BCLK) in the system clock domain and delivers stereo PCM frames

---
 rtl/audio_adc_rx.sv | 178 +++++++++++++++++
 tb/tb_audio_adc_rx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_rx.sv
// Captures WM8731 I2S ADC frames into the system clock domain and tracks a windowed peak level.
// A frame appears a few clocks after its last right bit; while the held frame is unaccepted, new frames are dropped and flagged.
module audio_adc_rx #(
    parameter int DATA_WIDTH    = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int WINDOW_FRAMES = 1024
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic                  audio_interface_ADCDAT,
    input  logic                  audio_interface_ADCLRCK,
    input  logic                  audio_interface_BCLK,
    output logic [DATA_WIDTH-1:0] sample_left,
    output logic [DATA_WIDTH-1:0] sample_right,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic [DATA_WIDTH-1:0] peak_level,
    output logic                  peak_valid
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int FW = (WINDOW_FRAMES > 1) ? $clog2(WINDOW_FRAMES) : 1;

    localparam logic [1:0] ST_ALIGN = 2'd0;
    localparam logic [1:0] ST_SKIP  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [SYNC_STAGES-1:0] bclk_sr, lrck_sr, dat_sr;
    logic                   bclk_s, lrck_s, dat_s;
    logic                   bclk_prev, lrck_last;
    logic                   bclk_rise, boundary;
    logic [1:0]             state;
    logic                   chan;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_WIDTH-1:0]  shreg, shreg_ins, left_hold;
    logic                   word_done, frame_done;
    logic [DATA_WIDTH-1:0]  word_val;
    logic [DATA_WIDTH-1:0]  peak_acc, peak_next, mag_l, mag_r;
    logic [FW-1:0]          frm_cnt;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            bclk_sr <= '0;
            lrck_sr <= '0;
            dat_sr  <= '0;
        end else begin
            bclk_sr <= {bclk_sr[SYNC_STAGES-2:0], audio_interface_BCLK};
            lrck_sr <= {lrck_sr[SYNC_STAGES-2:0], audio_interface_ADCLRCK};
            dat_sr  <= {dat_sr[SYNC_STAGES-2:0], audio_interface_ADCDAT};
        end
    end

    assign bclk_s    = bclk_sr[SYNC_STAGES-1];
    assign lrck_s    = lrck_sr[SYNC_STAGES-1];
    assign dat_s     = dat_sr[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_prev;
    assign boundary  = bclk_rise & (lrck_s != lrck_last);

    // Bits land MSB-first at their final position, so a short word is already zero-filled.
    always_comb begin
        shreg_ins = shreg;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i == DATA_WIDTH - 1 - int'(bit_cnt)) shreg_ins[i] = dat_s;
        end
    end

    always_comb begin
        word_done = 1'b0;
        word_val  = shreg_ins;
        if (state == ST_SHIFT && bclk_rise) begin
            if (boundary) begin
                word_done = 1'b1;
                word_val  = shreg;
            end else if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                word_done = 1'b1;
            end
        end
    end

    assign frame_done = word_done & chan;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            bclk_prev <= 1'b0;
            lrck_last <= 1'b0;
            state     <= ST_ALIGN;
            chan      <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            left_hold <= '0;
        end else begin
            bclk_prev <= bclk_s;
            if (bclk_rise) lrck_last <= lrck_s;
            case (state)
                ST_ALIGN: if (boundary && !lrck_s) begin
                    state <= ST_SKIP;
                    chan  <= 1'b0;
                end
                ST_SKIP: begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: if (bclk_rise) begin
                    if (boundary) begin
                        state <= ST_SKIP;
                        chan  <= lrck_s;
                    end else begin
                        shreg   <= shreg_ins;
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == CW'(DATA_WIDTH - 1)) state <= ST_DONE;
                    end
                end
                ST_DONE: if (boundary) begin
                    state <= ST_SKIP;
                    chan  <= lrck_s;
                end
                default: state <= ST_ALIGN;
            endcase
            if (word_done && !chan) left_hold <= word_val;
        end
    end

    // The most negative code has no positive twin; clamp it to full scale.
    function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] x);
        if (!x[DATA_WIDTH-1]) return x;
        if (x == {1'b1, {(DATA_WIDTH-1){1'b0}}}) return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        return -x;
    endfunction

    always_comb begin
        mag_l     = mag(left_hold);
        mag_r     = mag(word_val);
        peak_next = peak_acc;
        if (mag_l > peak_next) peak_next = mag_l;
        if (mag_r > peak_next) peak_next = mag_r;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            peak_level   <= '0;
            peak_valid   <= 1'b0;
            peak_acc     <= '0;
            frm_cnt      <= '0;
        end else begin
            if (frame_done && (!sample_valid || sample_ready)) begin
                sample_left  <= left_hold;
                sample_right <= word_val;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (frame_done && sample_valid && !sample_ready) overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;

            // Dropped frames still count toward the loudness window.
            peak_valid <= 1'b0;
            if (frame_done) begin
                if (frm_cnt == FW'(WINDOW_FRAMES - 1)) begin
                    peak_level <= peak_next;
                    peak_valid <= 1'b1;
                    peak_acc   <= '0;
                    frm_cnt    <= '0;
                end else begin
                    peak_acc <= peak_next;
                    frm_cnt  <= frm_cnt + FW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: I2S bit-level driver, frame/peak reference queues, per-cycle output comparison.
module tb_audio_adc_rx;
    localparam int DW = 16;
    localparam int SS = 2;
    localparam int WF = 4;
    localparam int H  = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic adcdat = 1'b0, lrck = 1'b1, bclk = 1'b1;
    logic sample_ready = 1'b0, overrun_clr = 1'b0;
    logic [DW-1:0] sample_left, sample_right, peak_level;
    logic sample_valid, overrun, peak_valid;

    always #5 clk = ~clk;

    audio_adc_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .WINDOW_FRAMES(WF)) dut (
        .clk_clk(clk), .reset_reset(rst),
        .audio_interface_ADCDAT(adcdat), .audio_interface_ADCLRCK(lrck), .audio_interface_BCLK(bclk),
        .sample_left(sample_left), .sample_right(sample_right), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .overrun(overrun), .overrun_clr(overrun_clr),
        .peak_level(peak_level), .peak_valid(peak_valid)
    );

    typedef struct { logic [15:0] l; logic [15:0] r; } frame_t;
    frame_t exp_q[$];
    logic [15:0] pk_q[$];
    int n_chk = 0, n_pass = 0;
    int acc_m = 0, cnt_m = 0;
    logic last_bit_s = 1'b0;
    realtime bit_t = 0, rise_t = 0;
    event right_last;
    int valid_cycles = 0, peak_pulses = 0;
    logic [15:0] last_peak = 0, acc_l = 0, acc_r = 0;
    int ready_mode = 0;
    logic ready_val = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int mag16(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    // Bits 1..n-1 of a slot are capturable; anything beyond DW is ignored, a short slot is zero-filled.
    function automatic logic [15:0] exp_word(input logic [31:0] s, input int n);
        int keep;
        logic [15:0] top, m;
        keep = (n - 1 >= DW) ? DW : n - 1;
        top  = s[31:16];
        m    = 16'hFFFF >> keep;
        return top & ~m;
    endfunction

    task automatic model_frame(input logic [15:0] l, input logic [15:0] r);
        if (mag16(l) > acc_m) acc_m = mag16(l);
        if (mag16(r) > acc_m) acc_m = mag16(r);
        cnt_m++;
        if (cnt_m == WF) begin
            pk_q.push_back(16'(acc_m));
            acc_m = 0;
            cnt_m = 0;
        end
    endtask

    task automatic send_slot(input logic ch, input logic [31:0] s, input int n, input logic is_right);
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            bclk = 1'b0;
            if (b == 0) lrck = ch;
            adcdat = (b == 0) ? last_bit_s : s[32-b];
            repeat (H) @(negedge clk);
            bclk = 1'b1;
            if (is_right && b == DW && n > DW) begin
                bit_t = $realtime;
                -> right_last;
            end
            repeat (H - 1) @(negedge clk);
        end
        last_bit_s = s[32-n];
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int n,
                              input logic [15:0] pad, input logic count_it);
        logic [31:0] sl, sr;
        frame_t f;
        sl = {l, pad};
        sr = {r, pad};
        if (count_it) begin
            f.l = exp_word(sl, n);
            f.r = exp_word(sr, n);
            exp_q.push_back(f);
            model_frame(f.l, f.r);
        end
        send_slot(1'b0, sl, n, 1'b0);
        send_slot(1'b1, sr, n, 1'b1);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || sample_valid) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_in_time", 32'(t < 5000), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            sample_ready = (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : ready_val;
        end
    end

    // Per-cycle comparison against the reference queues.
    logic pv = 1'b0, pr = 1'b0;
    logic [15:0] pl = 0, prr = 0;
    always @(negedge clk) begin
        frame_t f;
        if (rst) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", 32'(sample_valid), 32'd1);
                chk("hold_left", 32'(sample_left), 32'(pl));
                chk("hold_right", 32'(sample_right), 32'(prr));
            end
            if (sample_valid && !pv) rise_t = $realtime;
            if (sample_valid && sample_ready) begin
                valid_cycles++;
                acc_l = sample_left;
                acc_r = sample_right;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_frame: got L=%0h R=%0h, expected no frame", sample_left, sample_right);
                end else begin
                    f = exp_q.pop_front();
                    chk("frame_left", 32'(sample_left), 32'(f.l));
                    chk("frame_right", 32'(sample_right), 32'(f.r));
                end
            end
            if (peak_valid) begin
                peak_pulses++;
                last_peak = peak_level;
                if (pk_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_peak: got %0h, expected no pulse", peak_level);
                end else begin
                    chk("peak_level", 32'(peak_level), 32'(pk_q.pop_front()));
                end
            end
            pv  = sample_valid;
            pr  = sample_ready;
            pl  = sample_left;
            prr = sample_right;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] a_l, d_l, y_l;
        int n;
        ready_mode = 0;
        ready_val  = 1'b1;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_data", {sample_left, sample_right}, 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_peak", {15'd0, peak_valid, peak_level}, 32'd0);
        rst = 1'b0;
        acc_m = 0;
        cnt_m = 0;
        repeat (10) @(negedge clk);

        // Peak windows of four frames.
        send_frame(16'd100, 16'hFED4, 20, 16'h0, 1'b1);
        send_frame(16'h8000, 16'd5, 20, 16'h0, 1'b1);
        send_frame(16'd7, 16'd7, 20, 16'h0, 1'b1);
        send_frame(16'd0, 16'd0, 20, 16'h0, 1'b1);
        drain();
        chk("win1_pulses", 32'(peak_pulses), 32'd1);
        chk("win1_peak", 32'(last_peak), 32'd32767);
        send_frame(16'd3, 16'hFFF7, 20, 16'h0, 1'b1);
        send_frame(16'd1, 16'd2, 20, 16'h0, 1'b1);
        send_frame(16'd0, 16'd0, 20, 16'h0, 1'b1);
        send_frame(16'hFFFC, 16'd4, 20, 16'h0, 1'b1);
        drain();
        chk("win2_pulses", 32'(peak_pulses), 32'd2);
        chk("win2_peak", 32'(last_peak), 32'd9);

        // Basic frame, single valid pulse and latency.
        n = valid_cycles;
        send_frame(16'h1234, 16'hFEDC, 20, 16'h0, 1'b1);
        drain();
        chk("t1_pulses", 32'(valid_cycles - n), 32'd1);
        chk("t1_left", 32'(acc_l), 32'h1234);
        chk("t1_right", 32'(acc_r), 32'hFEDC);
        chk("t1_overrun", 32'(overrun), 32'd0);
        chk("t1_latency", 32'((rise_t > bit_t) && (rise_t - bit_t <= real'((SS + 3) * 10))), 32'd1);

        // 24-bit slot with trailing ones.
        send_frame(16'hA5C3, 16'h8001, 24, 16'hFF00, 1'b1);
        drain();
        chk("t5_left", 32'(acc_l), 32'hA5C3);
        chk("t5_right", 32'(acc_r), 32'h8001);

        // Acceptance in the same cycle a new frame completes.
        ready_val = 1'b0;
        send_frame(16'hF00D, 16'h0BAD, 20, 16'h0, 1'b1);
        y_l = 16'h7E57;
        fork
            send_frame(y_l, 16'h5EED, 20, 16'h0, 1'b1);
            begin
                @(right_last);
                @(negedge clk);
                ready_val = 1'b1;
            end
        join
        drain();
        chk("t6_overrun", 32'(overrun), 32'd0);
        chk("t6_left", 32'(acc_l), 32'(y_l));

        // Back-pressure for three frames: A held, B and C dropped.
        ready_val = 1'b0;
        a_l = 16'h0A0A;
        send_frame(a_l, 16'h1A1A, 20, 16'h0, 1'b1);
        repeat (5) @(negedge clk);
        chk("t3_a_valid", 32'(sample_valid), 32'd1);
        chk("t3_a_no_overrun", 32'(overrun), 32'd0);
        send_frame(16'h0B0B, 16'h1B1B, 20, 16'h0, 1'b1);
        repeat (5) @(negedge clk);
        chk("t3_b_overrun", 32'(overrun), 32'd1);
        send_frame(16'h0C0C, 16'h1C1C, 20, 16'h0, 1'b1);
        repeat (5) @(negedge clk);
        chk("t3_a_held", 32'(sample_left), 32'(a_l));
        chk("t3_queue", 32'(exp_q.size()), 32'd3);
        if (exp_q.size() == 3) begin
            exp_q.delete(2);
            exp_q.delete(1);
        end
        ready_val = 1'b1;
        drain();
        chk("t3_a_accepted", 32'(acc_l), 32'(a_l));
        d_l = 16'h0D0D;
        send_frame(d_l, 16'h1D1D, 20, 16'h0, 1'b1);
        drain();
        chk("t3_d_delivered", 32'(acc_l), 32'(d_l));
        chk("t3_overrun_sticky", 32'(overrun), 32'd1);
        @(posedge clk);
        #1 overrun_clr = 1'b1;
        @(posedge clk);
        #1 overrun_clr = 1'b0;
        @(negedge clk);
        chk("t3_overrun_clr", 32'(overrun), 32'd0);

        // Reset asserted mid-left, released mid-right: that frame never appears.
        n = valid_cycles;
        fork
            send_frame(16'hDEAD, 16'hBEEF, 20, 16'h0, 1'b0);
            begin
                repeat (100) @(negedge clk);
                rst = 1'b1;
                acc_m = 0;
                cnt_m = 0;
                repeat (3) @(negedge clk);
                chk("t2_rst_valid", 32'(sample_valid), 32'd0);
                chk("t2_rst_overrun", 32'(overrun), 32'd0);
                repeat (147) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        chk("t2_no_output", 32'(valid_cycles - n), 32'd0);
        send_frame(16'h2468, 16'h9BDF, 20, 16'h0, 1'b1);
        drain();
        chk("t2_first_left", 32'(acc_l), 32'h2468);
        chk("t2_first_right", 32'(acc_r), 32'h9BDF);

        // Random frames, slot widths and short back-pressure bursts.
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: n = 12;
                1: n = 17;
                2: n = 20;
                default: n = 24;
            endcase
            if (i == 39) n = 20;
            send_frame(16'($urandom), 16'($urandom), n, 16'($urandom), 1'b1);
        end
        drain();
        ready_mode = 0;
        ready_val  = 1'b1;
        repeat (5) @(negedge clk);
        chk("rand_overrun", 32'(overrun), 32'd0);
        chk("rand_frames_left", 32'(exp_q.size()), 32'd0);
        chk("rand_peaks_left", 32'(pk_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
